eh2_ifu_fetch_buf: RTL
======================

Name: eh2_ifu_fetch_buf

Overview:
- Fetch buffer directly downstream of the IFU fetch controller.
- Captures each F2 fetch packet (64-bit I-cache/ICCM data, PC, fault status) on an F2 hit.
- Presents the two oldest packets to the aligner.
- Returns per-cycle consume indications (ifu_fb_consume1 / ifu_fb_consume2) to the fetch controller, which uses them for its own write-pointer and full tracking.

Parameters:
- FB_DEPTH, 4, number of packet entries; power of two, minimum 2.
- FB_PTR_W, 2, log2(FB_DEPTH).
- FB_DATA_W, 64, fetch packet data width.

Ports:
- clk  in  1  gated core clock
- rst_l  in  1  asynchronous active-low reset
- fetch_req_f2  in  1  F2 fetch valid, already flush-qualified
- ic_hit_f2  in  1  F2 data returned (I-cache hit, ICCM hit or critical word)
- ic_data_f2  in  FB_DATA_W  F2 packet data
- fetch_addr_f2  in  31  F2 packet PC, bits [31:1]
- ic_access_fault_f2  in  1  F2 access fault, stored with the packet
- exu_flush_final  in  1  pipeline flush
- aln_consume1  in  1  aligner retires the oldest entry
- aln_consume2  in  1  aligner retires the two oldest entries
- ifu_fb_consume1  out  1  qualified single consume, to the fetch controller
- ifu_fb_consume2  out  1  qualified double consume, to the fetch controller
- fb_valid  out  2  bit i set = entry i (0 = oldest) valid
- fb_data0, fb_data1  out  FB_DATA_W  data of oldest and second-oldest entry
- fb_pc0, fb_pc1  out  31  PC of those entries
- fb_fault0, fb_fault1  out  1  fault flag of those entries
- fb_count  out  FB_PTR_W+1  occupied entries
- fb_full  out  1  fb_count == FB_DEPTH
- fb_overflow  out  1  sticky error flag: a write was dropped

Behaviour:
- Clocking and reset: one clock (clk); reset rst_l is asynchronous and active-low.
  - Reset clears rd_ptr, wr_ptr, count, all entry valid bits and fb_overflow.
  - Every output is 0 at reset.
- Storage: circular array of FB_DEPTH entries {data, pc, fault}.
  - Pointers wrap modulo FB_DEPTH.
  - count ranges 0..FB_DEPTH, held in FB_PTR_W+1 bits.
- Write (wr_en): wr_en = fetch_req_f2 & ic_hit_f2 & ~exu_flush_final & (count - cons_n < FB_DEPTH).
  - cons_n is the number of entries retired in the same cycle (0, 1 or 2).
  - A write into a full buffer is therefore accepted only when a consume occurs in the same cycle.
  - On wr_en, the entry at wr_ptr is stored and wr_ptr increments.
  - Default latency: a written entry is visible on the outputs on the next cycle.
- Consume qualification:
  - ifu_fb_consume2 = aln_consume2 & fb_valid[1] & ~exu_flush_final.
  - ifu_fb_consume1 = aln_consume1 & ~aln_consume2 & fb_valid[0] & ~exu_flush_final.
  - If both aln_consume inputs are asserted, consume2 wins; this is an illegal input and fires an assertion.
  - rd_ptr advances by cons_n.
- Outputs:
  - fb_valid[0] = count >= 1; fb_valid[1] = count >= 2.
  - Data, PC and fault outputs read entries rd_ptr and rd_ptr+1 (modulo FB_DEPTH).
  - Outputs for entries that are not valid carry 0.
- Count update: count_next = count + wr_en - cons_n, applied in one cycle.
- Flush: exu_flush_final forces rd_ptr = wr_ptr = count = 0 on the next cycle.
  - Any same-cycle write or consume is discarded, and both consume outputs are 0 that cycle.
- Overflow: if fetch_req_f2 & ic_hit_f2 & ~flush while the buffer is full and cons_n == 0:
  - the write is dropped, fb_overflow sets and stays set until reset, and an assertion fires.
- Wrap-around: a consume2 whose entries span index FB_DEPTH-1 and index 0 is legal.

Optional Feature:
- Macro: RV_IFU_FB_BYPASS_EN.
- When defined and count == 0: a same-cycle F2 hit drives fb_valid[0], fb_data0, fb_pc0 and fb_fault0 combinationally from the F2 inputs.
  - If aln_consume1 is asserted that cycle, the packet is retired without being stored, and count and pointers stay unchanged.
  - Otherwise the packet is stored normally.
- When not defined: no bypass; an empty buffer shows fb_valid = 0 in the write cycle.

Decomposition:
- Shared package eh2_pkg holds:
  - typedef eh2_fb_entry_t {data, pc[31:1], fault};
  - constant FB_DEPTH_DEF.
- One sub-module, eh2_ifu_fb_entry: a single enable-loaded entry register with valid bit, instantiated FB_DEPTH times.
- Pointer, count and mux logic stay in the parent.

Test Plan:
- Reset, then write 4 packets (PC 0x100, 0x104, 0x108, 0x10C) on consecutive cycles with no consume -> fb_count = 4, fb_full = 1, fb_pc0 = 0x100, fb_pc1 = 0x104.
- Buffer full, aln_consume1 plus a write of PC 0x110 in the same cycle -> write accepted, fb_count stays 4, fb_pc0 = 0x104, fb_overflow = 0.
- Full buffer, write with no consume -> write dropped, fb_overflow = 1 and sticky, fb_count = 4.
- Pointers at rd = 3, wr = 1 (2 entries) with aln_consume2 -> ifu_fb_consume2 = 1, fb_count = 0, fb_valid = 00 next cycle.
- 3 entries valid, then exu_flush_final together with an F2 hit and aln_consume1 -> both consume outputs 0, next cycle fb_count = 0 and fb_valid = 00.
- RV_IFU_FB_BYPASS_EN defined, empty buffer, F2 hit at PC 0x200 with aln_consume1 in the same cycle -> fb_valid[0] = 1 and fb_pc0 = 0x200 in that cycle, fb_count = 0 next cycle. Without the macro: fb_valid = 00 that cycle, fb_count = 1 next cycle.

Source files
------------

// File: rtl/eh2_pkg.sv
// Shared fetch-buffer types and defaults: one packet entry is {data, pc[31:1], fault}.
package eh2_pkg;

  localparam int FB_DEPTH_DEF  = 4;
  localparam int FB_PTR_W_DEF  = 2;
  localparam int FB_DATA_W_DEF = 64;

  typedef struct packed {
    logic [FB_DATA_W_DEF-1:0] data;
    logic [31:1]              pc;
    logic                     fault;
  } eh2_fb_entry_t;

endpackage

// File: rtl/eh2_ifu_fb_entry.sv
// One fetch-buffer slot: packet register loaded on wr_en, plus a valid bit that
// is set by a write and cleared by a retire or a flush.
module eh2_ifu_fb_entry
  import eh2_pkg::*;
(
  input  logic          clk,
  input  logic          rst_l,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_clr,
  input  eh2_fb_entry_t wr_entry,
  output eh2_fb_entry_t entry,
  output logic          valid
);

  eh2_fb_entry_t entry_q, entry_d;
  logic          valid_q, valid_d;

  // A write and a retire of the same slot only meet when the buffer is full;
  // the new packet must survive, so the write takes priority.
  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    if (wr_en) entry_d = wr_entry;
    if (flush)       valid_d = 1'b0;
    else if (wr_en)  valid_d = 1'b1;
    else if (rd_clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  assign entry = entry_q;
  assign valid = valid_q;

endmodule

// File: rtl/eh2_ifu_fetch_buf.sv
// IFU fetch buffer: circular packet store between F2 and the aligner.
// Optional `RV_IFU_FB_BYPASS_EN shows an F2 hit on slot 0 when empty; `RV_ASSERT_ON enables checks.
module eh2_ifu_fetch_buf
  import eh2_pkg::*;
#(
  parameter int FB_DEPTH  = FB_DEPTH_DEF,
  parameter int FB_PTR_W  = FB_PTR_W_DEF,
  parameter int FB_DATA_W = FB_DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 fetch_req_f2,
  input  logic                 ic_hit_f2,
  input  logic [FB_DATA_W-1:0] ic_data_f2,
  input  logic [31:1]          fetch_addr_f2,
  input  logic                 ic_access_fault_f2,
  input  logic                 exu_flush_final,
  input  logic                 aln_consume1,
  input  logic                 aln_consume2,
  output logic                 ifu_fb_consume1,
  output logic                 ifu_fb_consume2,
  output logic [1:0]           fb_valid,
  output logic [FB_DATA_W-1:0] fb_data0,
  output logic [FB_DATA_W-1:0] fb_data1,
  output logic [31:1]          fb_pc0,
  output logic [31:1]          fb_pc1,
  output logic                 fb_fault0,
  output logic                 fb_fault1,
  output logic [FB_PTR_W:0]    fb_count,
  output logic                 fb_full,
  output logic                 fb_overflow
);

  localparam logic [FB_PTR_W:0] DEPTH_C = (FB_PTR_W+1)'(FB_DEPTH);
  localparam logic [FB_PTR_W:0] ONE_C   = (FB_PTR_W+1)'(1);
  localparam logic [FB_PTR_W:0] TWO_C   = (FB_PTR_W+1)'(2);

  logic [FB_PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1;
  logic [FB_PTR_W:0]   count_q, count_d, cons_n;
  logic                overflow_q, overflow_d;
  logic                f2_hit, bypass, bypass_retire, wr_en, drop;
  logic [1:0]          stored_valid;
  logic [FB_DEPTH-1:0] ent_valid, ent_wr, ent_clr;
  eh2_fb_entry_t       wr_entry;
  eh2_fb_entry_t       ent [FB_DEPTH];

  assign f2_hit  = fetch_req_f2 & ic_hit_f2 & ~exu_flush_final;
  assign rd_ptr1 = rd_ptr_q + 1'b1;

  assign stored_valid[0] = (count_q != '0)    & ent_valid[rd_ptr_q];
  assign stored_valid[1] = (count_q >= TWO_C) & ent_valid[rd_ptr1];

`ifdef RV_IFU_FB_BYPASS_EN
  assign bypass = f2_hit & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign fb_valid = {stored_valid[1], stored_valid[0] | bypass};

  // Consume handshake: aln_consumeN is the aligner's request, valid only against
  // the fb_valid shown that cycle; ifu_fb_consumeN is the retire that actually
  // happens and is what the fetch controller must track. Flush cancels both.
  assign ifu_fb_consume2 = aln_consume2 & fb_valid[1] & ~exu_flush_final;
  assign ifu_fb_consume1 = aln_consume1 & ~aln_consume2 & fb_valid[0] & ~exu_flush_final;
  assign bypass_retire   = bypass & ifu_fb_consume1;

  always_comb begin
    cons_n = '0;
    if (ifu_fb_consume2)                cons_n = TWO_C;
    else if (ifu_fb_consume1 & ~bypass) cons_n = ONE_C;
  end

  assign wr_en = f2_hit & ~bypass_retire & ((count_q - cons_n) < DEPTH_C);
  assign drop  = f2_hit & (count_q == DEPTH_C) & (cons_n == '0);

  always_comb begin
    rd_ptr_d   = rd_ptr_q + cons_n[FB_PTR_W-1:0];
    wr_ptr_d   = wr_ptr_q + FB_PTR_W'(wr_en);
    count_d    = count_q + (FB_PTR_W+1)'(wr_en) - cons_n;
    overflow_d = overflow_q | drop;
    if (exu_flush_final) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_entry.data  = ic_data_f2;
  assign wr_entry.pc    = fetch_addr_f2;
  assign wr_entry.fault = ic_access_fault_f2;

  for (genvar i = 0; i < FB_DEPTH; i++) begin : g_ent
    assign ent_wr[i]  = wr_en & (wr_ptr_q == FB_PTR_W'(i));
    assign ent_clr[i] = ((cons_n != '0)    & (rd_ptr_q == FB_PTR_W'(i))) |
                        ((cons_n == TWO_C) & (rd_ptr1  == FB_PTR_W'(i)));
    eh2_ifu_fb_entry u_ent (
      .clk      (clk),
      .rst_l    (rst_l),
      .flush    (exu_flush_final),
      .wr_en    (ent_wr[i]),
      .rd_clr   (ent_clr[i]),
      .wr_entry (wr_entry),
      .entry    (ent[i]),
      .valid    (ent_valid[i])
    );
  end

  always_comb begin
    fb_data0  = '0;
    fb_pc0    = '0;
    fb_fault0 = 1'b0;
    fb_data1  = '0;
    fb_pc1    = '0;
    fb_fault1 = 1'b0;
    if (bypass) begin
      fb_data0  = ic_data_f2;
      fb_pc0    = fetch_addr_f2;
      fb_fault0 = ic_access_fault_f2;
    end else if (stored_valid[0]) begin
      fb_data0  = ent[rd_ptr_q].data;
      fb_pc0    = ent[rd_ptr_q].pc;
      fb_fault0 = ent[rd_ptr_q].fault;
    end
    if (stored_valid[1]) begin
      fb_data1  = ent[rd_ptr1].data;
      fb_pc1    = ent[rd_ptr1].pc;
      fb_fault1 = ent[rd_ptr1].fault;
    end
  end

  assign fb_count    = count_q;
  assign fb_full     = (count_q == DEPTH_C);
  assign fb_overflow = overflow_q;

`ifdef RV_ASSERT_ON
  a_consume_both: assert property (@(posedge clk) disable iff (!rst_l)
    !(aln_consume1 & aln_consume2))
    else $error("aln_consume1 and aln_consume2 asserted together");
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l) !drop)
    else $error("fetch buffer write dropped while full");
`endif

endmodule
